// File: rtl/deser160_pkg.sv
// Shared types and default sizing for the 160 MHz deserializer phase calibration.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package deser160_pkg;

    localparam int DEF_NPHASE = 8;
    localparam int DEF_PW     = 3;
    localparam int DEF_SETTLE = 16;
    localparam int DEF_WINDOW = 256;
    localparam int DEF_CW     = 9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_EVAL    = 3'd3,
        ST_APPLY   = 3'd4
    } cal_state_t;

    typedef logic [DEF_PW-1:0] phase_idx_t;

endpackage

// File: rtl/deser160_match_counter.sv
// Strobe-qualified window counter: counts sync strobes and pattern matches up to a terminal count.
// Latency: window_end is combinational on the strobe that reaches the terminal count; counts update next clk.
// Backpressure: none; idle clk cycles (sync=0) do not advance the counters.
module deser160_match_counter
    import deser160_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          clr,
    input  logic          sync,
    input  logic          match,
    input  logic [CW-1:0] term,
    output logic [CW-1:0] match_cnt,
    output logic          window_end
);

    logic [CW-1:0] strobe_cnt_q, strobe_cnt_d;
    logic [CW-1:0] match_cnt_q, match_cnt_d;

    // Terminal strobe is flagged independently of clr so the controller can clear on it.
    assign window_end = en && sync && (strobe_cnt_q == term - 1'b1);
    assign match_cnt  = match_cnt_q;

    // Clear has priority; otherwise each qualified strobe advances, matches saturate at term.
    always_comb begin
        strobe_cnt_d = strobe_cnt_q;
        match_cnt_d  = match_cnt_q;
        if (clr) begin
            strobe_cnt_d = '0;
            match_cnt_d  = '0;
        end else if (en && sync) begin
            strobe_cnt_d = strobe_cnt_q + 1'b1;
            if (match && (match_cnt_q < term)) begin
                match_cnt_d = match_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            strobe_cnt_q <= '0;
            match_cnt_q  <= '0;
        end else begin
            strobe_cnt_q <= strobe_cnt_d;
            match_cnt_q  <= match_cnt_d;
        end
    end

endmodule

// File: rtl/deser160_phase_calib.sv
// Sweeps the sampling phase, scores each against the training nibble, and applies the centre of the longest perfect run.
// Latency: NPHASE*(SETTLE+WINDOW+1)+2 clk from start to done with sync every clk.
// Backpressure: progress is paced by sync strobes only; start is ignored while busy.
module deser160_phase_calib
    import deser160_pkg::*;
#(
    parameter int NPHASE = DEF_NPHASE,
    parameter int PW     = DEF_PW,
    parameter int SETTLE = DEF_SETTLE,
    parameter int WINDOW = DEF_WINDOW,
    parameter int CW     = DEF_CW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sync,
    input  logic [3:0]    data,
    input  logic [3:0]    pattern,
    input  logic          start,
    output logic [PW-1:0] phase_sel,
    output logic          busy,
    output logic          done,
    output logic          locked,
    output logic [PW:0]   best_len,
    output logic [CW-1:0] best_cnt
);

    localparam logic [CW-1:0] SETTLE_TC = CW'(SETTLE);
    localparam logic [CW-1:0] WINDOW_TC = CW'(WINDOW);
    localparam logic [PW-1:0] LAST_PH   = PW'(NPHASE - 1);

    cal_state_t    state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [PW-1:0] phase_sel_q, phase_sel_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          locked_q, locked_d;
    logic [PW:0]   best_len_q, best_len_d;
    logic [PW-1:0] best_start_q, best_start_d;
    logic [PW:0]   cur_len_q, cur_len_d;
    logic [PW-1:0] cur_start_q, cur_start_d;
    logic [CW-1:0] best_cnt_q, best_cnt_d;
    logic [PW-1:0] max_ph_q, max_ph_d;

    logic          cnt_en, cnt_clr, window_end;
    logic [CW-1:0] cnt_term, m_cnt;
    logic          perfect, last_ph;
    logic [PW:0]   run_len;
    logic [PW-1:0] run_start;

    // The same counter measures the settle period and the match window; only the terminal count differs.
    assign cnt_en   = (state_q == ST_SETTLE) || (state_q == ST_MEASURE);
    assign cnt_term = (state_q == ST_MEASURE) ? WINDOW_TC : SETTLE_TC;
    assign perfect  = (m_cnt == WINDOW_TC);
    assign last_ph  = (p_q == LAST_PH);

    deser160_match_counter #(.CW(CW)) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (cnt_en),
        .clr        (cnt_clr),
        .sync       (sync),
        .match      (data == pattern),
        .term       (cnt_term),
        .match_cnt  (m_cnt),
        .window_end (window_end)
    );

    // Next-state and next-output computation for the calibration sequence.
    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        phase_sel_d  = phase_sel_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        locked_d     = locked_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        cur_len_d    = cur_len_q;
        cur_start_d  = cur_start_q;
        best_cnt_d   = best_cnt_q;
        max_ph_d     = max_ph_q;
        cnt_clr      = 1'b0;
        run_len      = cur_len_q;
        run_start    = cur_start_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    p_d          = '0;
                    phase_sel_d  = '0;
                    busy_d       = 1'b1;
                    locked_d     = 1'b0;
                    best_len_d   = '0;
                    best_start_d = '0;
                    cur_len_d    = '0;
                    cur_start_d  = '0;
                    best_cnt_d   = '0;
                    max_ph_d     = '0;
                    cnt_clr      = 1'b1;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (window_end) begin
                    cnt_clr = 1'b1;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // Match count is kept until EVAL has consumed it.
                if (window_end) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                cnt_clr = 1'b1;
                // Strictly greater: ties keep the lower phase.
                if (m_cnt > best_cnt_q) begin
                    best_cnt_d = m_cnt;
                    max_ph_d   = p_q;
                end
                if (perfect) begin
                    if (cur_len_q == '0) begin
                        run_start = p_q;
                    end
                    run_len = cur_len_q + 1'b1;
                end
                // A run closes on an imperfect phase or at the top phase (no wrap to phase 0).
                if (!perfect || last_ph) begin
                    if (run_len > best_len_q) begin
                        best_len_d   = run_len;
                        best_start_d = run_start;
                    end
                    cur_len_d = '0;
                end else begin
                    cur_len_d   = run_len;
                    cur_start_d = run_start;
                end
                if (last_ph) begin
                    state_d = ST_APPLY;
                end else begin
                    p_d         = p_q + 1'b1;
                    phase_sel_d = p_q + 1'b1;
                    state_d     = ST_SETTLE;
                end
            end
            ST_APPLY: begin
                if (best_len_q != '0) begin
                    phase_sel_d = best_start_q + PW'((best_len_q - 1'b1) >> 1);
                    locked_d    = 1'b1;
                end else begin
                    phase_sel_d = max_ph_q;
                    locked_d    = 1'b0;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Single registered FSM: state, trackers and all outputs; reset aborts without a done pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            p_q          <= '0;
            phase_sel_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            locked_q     <= 1'b0;
            best_len_q   <= '0;
            best_start_q <= '0;
            cur_len_q    <= '0;
            cur_start_q  <= '0;
            best_cnt_q   <= '0;
            max_ph_q     <= '0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            phase_sel_q  <= phase_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            locked_q     <= locked_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            cur_len_q    <= cur_len_d;
            cur_start_q  <= cur_start_d;
            best_cnt_q   <= best_cnt_d;
            max_ph_q     <= max_ph_d;
        end
    end

    assign phase_sel = phase_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign locked    = locked_q;
    assign best_len  = best_len_q;
    assign best_cnt  = best_cnt_q;

endmodule

// File: doc/deser160_phase_calib.md
Name: deser160_phase_calib

Overview:
Calibration controller for the 160 MHz deserializer sampling stage. It steps the sampling-clock phase select through NPHASE candidates and counts matches of the deserialized 4-bit nibbles against a known training pattern for each phase. It then drives the centre of the longest error-free phase run to the clock phase mux. It sits between the deserializer nibble output (data qualified by sync) and the sclk phase-select logic, and is started by the control register block.

Parameters:
NPHASE, 8, number of selectable sampling phases (power of 2, 2..16)
PW, 3, phase-select width = log2(NPHASE)
SETTLE, 16, sync strobes discarded after each phase change
WINDOW, 256, sync strobes measured per phase (power of 2)
CW, 9, counter width = log2(WINDOW)+1

Ports:
clk  in  1  system clock, same domain as deserializer data/sync
reset_n  in  1  synchronous reset, active low
sync  in  1  nibble-valid strobe, one clk per nibble
data  in  4  deserialized nibble
pattern  in  4  expected training nibble, static during calibration
start  in  1  single-cycle pulse, begin calibration
phase_sel  out  PW  sampling phase to clock mux
busy  out  1  calibration in progress
done  out  1  single-cycle pulse at calibration end
locked  out  1  at least one error-free phase found
best_len  out  PW+1  length of the chosen error-free run
best_cnt  out  CW  highest match count over all phases

Behaviour:
- Reset (reset_n=0 at a clk edge): phase_sel=0, busy=0, done=0, locked=0, best_len=0, best_cnt=0, FSM=IDLE. A reset mid-calibration aborts it and does not pulse done.
- FSM states: IDLE, SETTLE, MEASURE, EVAL, APPLY.
- IDLE: start=1 -> phase index p=0, phase_sel=0, busy=1, clear run trackers, locked=0 -> SETTLE. start is ignored while busy.
- SETTLE: count sync strobes. After SETTLE strobes -> MEASURE with match counter m=0. Strobes only; idle clk cycles do not count.
- MEASURE: on each sync, m+=1 if data==pattern. After WINDOW strobes -> EVAL. m saturates at WINDOW, so CW bits are required.
- EVAL (1 clk):
  - best_cnt = max(best_cnt, m).
  - Phase p counts as perfect when m==WINDOW. Perfect phases extend the current run (cur_start, cur_len); an imperfect phase closes it.
  - A closed run replaces the best run only when its length is strictly greater, so ties keep the earlier run.
  - Max-count phase: strictly greater replaces, so ties keep the lower phase.
  - If p<NPHASE-1: p+=1, phase_sel=p+1 -> SETTLE. Otherwise close any open run -> APPLY.
  - Runs do not wrap from NPHASE-1 to 0.
- APPLY (1 clk):
  - best_len>0: phase_sel = best_start + (best_len-1)/2 (integer division, truncated), locked=1.
  - best_len==0: phase_sel = max-count phase, locked=0.
  - busy=0, done=1 for this cycle -> IDLE.
- phase_sel changes only on entry to SETTLE or in APPLY, and holds otherwise.
- Latency with continuous sync: NPHASE*(SETTLE+WINDOW+1)+2 clk from start to done.
- Outputs hold after done until the next start or reset. best_len, best_cnt and locked clear at start.
- sync with pattern changing during calibration: behaviour undefined. Software must hold pattern stable.

Decomposition:
- Shared package deser160_pkg: FSM state enum (IDLE/SETTLE/MEASURE/EVAL/APPLY), default NPHASE/SETTLE/WINDOW constants, and a phase-index typedef.
- One natural sub-module: deser160_match_counter, the strobe-qualified window counter. It counts strobes and matches and asserts window_end. It is reused in both SETTLE and MEASURE with a different terminal count.

Test Plan:
- Error-free run in the middle: model phases 2..5 perfect, others at 50% match -> done pulses, locked=1, best_len=4, phase_sel=3, best_cnt=256.
- No perfect phase: counts per phase {10,40,200,200,90,0,0,5} -> locked=0, phase_sel=2 (tie keeps lower), best_cnt=200, best_len=0.
- Two equal runs: phases 0..1 and 5..6 perfect -> best_len=2, phase_sel=0 (earlier run wins, (2-1)/2=0).
- Run touching top edge: phases 6..7 perfect, phase 0 perfect -> no wrap, best_len=2, phase_sel=6.
- Sparse sync (one strobe every 4 clk): latency = 4*8*(16+256) clk plus EVAL/APPLY overhead, results identical to continuous sync.
- reset_n=0 during MEASURE of phase 3 -> next clk phase_sel=0, busy=0, no done. start after release -> full calibration completes normally. start while busy -> ignored.
